// File: rtl/ofdm_seq_pkg.sv
// rtl/ofdm_seq_pkg.sv - shared types and widths for the OFDM frame sequencer
package ofdm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    PAY,
    GAP,
    DONE
  } seq_state_t;

  localparam int WORD_CNT_W = 11;
  localparam int SYM_CNT_W  = 8;
  localparam int Q15_W      = 16;
  localparam int WORD_W     = 2 * Q15_W;

endpackage

// File: rtl/seq_out_reg.sv
// rtl/seq_out_reg.sv - single-entry registered output stage; a new word may load
// whenever the slot is empty or its current word is being taken this cycle
module seq_out_reg
  import ofdm_seq_pkg::*;
(
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              load,
  input  logic [WORD_W-1:0] load_dat,
  input  logic              ack,
  output logic              can_load,
  output logic [WORD_W-1:0] dat,
  output logic              stb
);

  assign can_load = ~stb | ack;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      dat <= '0;
      stb <= 1'b0;
    end else if (load) begin
      dat <= load_dat;
      stb <= 1'b1;
    end else if (stb && ack) begin
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/ofdm_frame_sequencer.sv
// rtl/ofdm_frame_sequencer.sv - sequences preamble then payload symbols as separate CYC_O bursts
// Optional SEQ_ABORT_EN adds FRM_ABORT_I: finish the current symbol, then end the frame.
module ofdm_frame_sequencer
  import ofdm_seq_pkg::*;
#(
  parameter int PRE_SYMS    = 2,
  parameter int DAT_PER_SYM = 1200,
  parameter int GAP_CYC     = 4
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 FRM_START_I,
  input  logic [SYM_CNT_W-1:0] FRM_NSYM_I,
  input  logic [WORD_W-1:0]    PRE_DAT_I,
  input  logic                 PRE_CYC_I,
  input  logic                 PRE_STB_I,
  input  logic                 PRE_WE_I,
  output logic                 PRE_ACK_O,
  input  logic [WORD_W-1:0]    PAY_DAT_I,
  input  logic                 PAY_CYC_I,
  input  logic                 PAY_STB_I,
  input  logic                 PAY_WE_I,
  output logic                 PAY_ACK_O,
  output logic [WORD_W-1:0]    DAT_O,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic                 WE_O,
  input  logic                 ACK_I,
  output logic                 BUSY_O,
  output logic [SYM_CNT_W-1:0] SYM_IDX_O,
  output logic                 FRM_DONE_O
`ifdef SEQ_ABORT_EN
  ,
  input  logic                 FRM_ABORT_I
`endif
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [SYM_CNT_W-1:0]  PRE_LIM  = SYM_CNT_W'(PRE_SYMS);
  localparam logic [WORD_CNT_W-1:0] WORD_LIM = WORD_CNT_W'(DAT_PER_SYM);
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'(GAP_CYC - 1);

  seq_state_t state_q, state_d;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [SYM_CNT_W-1:0]  pre_cnt, pay_cnt, nsym_q, sym_idx;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  in_sym, sel_pay, src_valid, can_load, accept, sym_end, abort_req;
  logic [WORD_W-1:0]     sel_dat;

  assign in_sym    = (state_q == PRE) || (state_q == PAY);
  assign sel_pay   = (state_q == PAY);
  assign src_valid = sel_pay ? (PAY_CYC_I & PAY_STB_I & PAY_WE_I)
                             : (PRE_CYC_I & PRE_STB_I & PRE_WE_I);
  assign sel_dat   = sel_pay ? PAY_DAT_I : PRE_DAT_I;
  // Reset gating keeps a source from seeing an accept that the reset will discard.
  assign accept    = in_sym & ~RST_I & src_valid & (word_cnt < WORD_LIM) & can_load;
  assign sym_end   = in_sym & (word_cnt == WORD_LIM) & STB_O & ACK_I;

  assign PRE_ACK_O  = accept & ~sel_pay;
  assign PAY_ACK_O  = accept & sel_pay;
  assign CYC_O      = in_sym;
  assign WE_O       = STB_O;
  assign BUSY_O     = (state_q != IDLE);
  assign FRM_DONE_O = (state_q == DONE);
  assign SYM_IDX_O  = sym_idx;

`ifdef SEQ_ABORT_EN
  logic abort_q;
  always_ff @(posedge CLK_I) begin
    if (RST_I || state_q == IDLE) abort_q <= 1'b0;
    else if (FRM_ABORT_I)         abort_q <= 1'b1;
  end
  assign abort_req = abort_q | FRM_ABORT_I;
`else
  assign abort_req = 1'b0;
`endif

  seq_out_reg u_out (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .load     (accept),
    .load_dat (sel_dat),
    .ack      (ACK_I),
    .can_load (can_load),
    .dat      (DAT_O),
    .stb      (STB_O)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (FRM_START_I) state_d = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (abort_req)               state_d = DONE;
          else if (pre_cnt < PRE_LIM)  state_d = PRE;
          else if (pay_cnt < nsym_q)   state_d = PAY;
          else                         state_d = DONE;
        end
      end
      PRE, PAY: if (sym_end) state_d = GAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= IDLE;
      word_cnt <= '0;
      pre_cnt  <= '0;
      pay_cnt  <= '0;
      nsym_q   <= '0;
      sym_idx  <= '0;
      gap_cnt  <= '0;
    end else begin
      state_q <= state_d;
      gap_cnt <= (state_q == GAP && state_d == GAP) ? gap_cnt + 1'b1 : '0;
      if (state_q == IDLE && FRM_START_I) begin
        nsym_q   <= FRM_NSYM_I;
        pre_cnt  <= '0;
        pay_cnt  <= '0;
        sym_idx  <= '0;
        word_cnt <= '0;
      end else if (sym_end) begin
        word_cnt <= '0;
        sym_idx  <= sym_idx + 1'b1;
        if (sel_pay) pay_cnt <= pay_cnt + 1'b1;
        else         pre_cnt <= pre_cnt + 1'b1;
      end else if (accept) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// tb/tb_ofdm_frame_sequencer.sv - frame-level model and directed scenarios for ofdm_frame_sequencer
module tb_ofdm_frame_sequencer;

  localparam int PRE = 2;
  localparam int DPS = 8;
  localparam int GAP = 4;
  localparam int PL  = PRE * DPS;

  logic        CLK_I = 1'b0;
  logic        RST_I, FRM_START_I, FRM_ABORT_I;
  logic [7:0]  FRM_NSYM_I;
  logic [31:0] PRE_DAT_I, PAY_DAT_I;
  logic        PRE_CYC_I, PRE_STB_I, PRE_WE_I, PRE_ACK_O;
  logic        PAY_CYC_I, PAY_STB_I, PAY_WE_I, PAY_ACK_O;
  logic [31:0] DAT_O;
  logic        CYC_O, STB_O, WE_O, ACK_I, BUSY_O, FRM_DONE_O;
  logic [7:0]  SYM_IDX_O;

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, mode = 0, exp_burst_len = 0, done_cnt = 0;
  int pre_seq = 0, pay_seq = 0;
  logic pre_ack_s = 1'b0, pay_ack_s = 1'b0;

  // frame model state, owned by the compare process
  logic f_active = 1'b0, cyc_prev = 1'b0, abort_seen = 1'b0;
  int   f_nsym = 0, pre_base = 0, pay_base = 0, hs_cnt = 0, acc_cnt = 0;
  int   f_bursts = 0, hs_burst = 0, high_run = 0, low_run = 0;

  ofdm_frame_sequencer #(.PRE_SYMS(PRE), .DAT_PER_SYM(DPS), .GAP_CYC(GAP)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .FRM_START_I(FRM_START_I), .FRM_NSYM_I(FRM_NSYM_I),
    .PRE_DAT_I(PRE_DAT_I), .PRE_CYC_I(PRE_CYC_I), .PRE_STB_I(PRE_STB_I), .PRE_WE_I(PRE_WE_I),
    .PRE_ACK_O(PRE_ACK_O),
    .PAY_DAT_I(PAY_DAT_I), .PAY_CYC_I(PAY_CYC_I), .PAY_STB_I(PAY_STB_I), .PAY_WE_I(PAY_WE_I),
    .PAY_ACK_O(PAY_ACK_O),
    .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .BUSY_O(BUSY_O), .SYM_IDX_O(SYM_IDX_O), .FRM_DONE_O(FRM_DONE_O)
`ifdef SEQ_ABORT_EN
    , .FRM_ABORT_I(FRM_ABORT_I)
`endif
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int k);
    if (k < PL) return {16'h1000, 16'(pre_base + k)};
    return {16'h2000, 16'(pay_base + k - PL)};
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge CLK_I) begin
    pre_ack_s = PRE_ACK_O;
    pay_ack_s = PAY_ACK_O;
    if (RST_I) begin
      f_active = 1'b0;
    end else if (!f_active) begin
      chk("idle_busy", BUSY_O, 0);
      chk("idle_cyc", CYC_O, 0);
      chk("idle_stb_we", {STB_O, WE_O}, 0);
      chk("idle_done", FRM_DONE_O, 0);
      chk("idle_acks", {PRE_ACK_O, PAY_ACK_O}, 0);
      if (FRM_START_I) begin
        f_active = 1'b1; f_nsym = FRM_NSYM_I; pre_base = pre_seq; pay_base = pay_seq;
        hs_cnt = 0; acc_cnt = 0; f_bursts = 0; hs_burst = 0; high_run = 0; low_run = 0;
        cyc_prev = 1'b0; abort_seen = 1'b0;
      end
    end else begin
      chk("busy", BUSY_O, 1);
      if (CYC_O) begin
        if (!cyc_prev) begin
          chk("gap_len", low_run, GAP);
          chk("burst_after_abort", abort_seen, 0);
          chk("sym_idx_start", SYM_IDX_O, 8'(f_bursts));
          f_bursts++; high_run = 0; hs_burst = 0;
        end
        high_run++;
      end else begin
        if (cyc_prev) begin
          if (exp_burst_len != 0) chk("burst_len", high_run, exp_burst_len);
          chk("burst_words", hs_burst, DPS);
          low_run = 0;
        end
        low_run++;
      end
      cyc_prev = CYC_O;
      if (STB_O) begin
        chk("stb_in_cyc", CYC_O, 1);
        chk("we", WE_O, 1);
        chk("dat", DAT_O, exp_word(hs_cnt));
        if (ACK_I) begin
          chk("sym_idx", SYM_IDX_O, 8'(hs_cnt / DPS));
          hs_cnt++; hs_burst++;
        end
      end
      if (PRE_ACK_O || PAY_ACK_O) begin
        chk("ack_excl", PRE_ACK_O & PAY_ACK_O, 0);
        chk("ack_src", PAY_ACK_O, acc_cnt >= PL);
        chk("ack_in_cyc", CYC_O, 1);
        acc_cnt++;
      end
      if (FRM_ABORT_I) abort_seen = 1'b1;
      if (FRM_DONE_O) begin
        chk("done_delay", low_run, GAP + 1);
        if (!abort_seen) chk("bursts", f_bursts, PRE + f_nsym);
        chk("words", hs_cnt, f_bursts * DPS);
        chk("pre_taken", pre_seq - pre_base, imin(f_bursts, PRE) * DPS);
        chk("pay_taken", pay_seq - pay_base, (f_bursts > PRE) ? (f_bursts - PRE) * DPS : 0);
        done_cnt++;
        f_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge CLK_I);
    #1;
    cyc++;
    if (pre_ack_s) pre_seq++;
    if (pay_ack_s) pay_seq++;
    PRE_DAT_I = {16'h1000, 16'(pre_seq)};
    PAY_DAT_I = {16'h2000, 16'(pay_seq)};
    case (mode)
      0: begin ACK_I = 1'b1; PRE_STB_I = 1'b1; PAY_STB_I = 1'b1; end
      1: begin ACK_I = ((cyc - t0) % 2) == 0; PRE_STB_I = 1'b1; PAY_STB_I = 1'b1; end
      default: begin
        ACK_I     = (cyc % 3) != 0;
        PRE_STB_I = (cyc % 5) != 2;
        PAY_STB_I = (cyc % 7) != 3;
      end
    endcase
  endtask

  task automatic start_frame(input int nsym, input int blen);
    exp_burst_len = blen;
    FRM_NSYM_I = 8'(nsym);
    FRM_START_I = 1'b1;
    t0 = cyc;
    step();
    FRM_START_I = 1'b0;
    FRM_NSYM_I = 8'd0;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    while (!FRM_DONE_O && n < 600) begin step(); n++; end
    chk({name, "_seen"}, FRM_DONE_O, 1);
    if (FRM_DONE_O && exp_lat > 0) chk({name, "_latency"}, cyc - t0, exp_lat);
    step();
  endtask

  task automatic wait_pay(input string name, input int n);
    int k = 0;
    while ((pay_seq - pay_base) < n && k < 300) begin step(); k++; end
    chk(name, (pay_seq - pay_base) >= n, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_dat"}, DAT_O, 0);
    chk({name, "_ctl"}, {CYC_O, STB_O, WE_O, BUSY_O, FRM_DONE_O, PRE_ACK_O, PAY_ACK_O}, 0);
    chk({name, "_sym_idx"}, SYM_IDX_O, 0);
  endtask

  initial begin
    RST_I = 1'b1; FRM_START_I = 1'b0; FRM_ABORT_I = 1'b0; FRM_NSYM_I = 8'd0;
    PRE_CYC_I = 1'b1; PRE_WE_I = 1'b1; PRE_STB_I = 1'b1;
    PAY_CYC_I = 1'b1; PAY_WE_I = 1'b1; PAY_STB_I = 1'b1;
    PRE_DAT_I = 32'h1000_0000; PAY_DAT_I = 32'h2000_0000; ACK_I = 1'b1;
    repeat (3) step();
    RST_I = 1'b0;
    #1;
    chk_all_zero("reset");
    step();

    // full-rate frame: 5 bursts of 9 cycles, 4-cycle gaps
    mode = 0;
    start_frame(3, DPS + 1);
    wait_done("full", 70);
    chk("full_bursts", f_bursts, 5);
    chk("full_words", hs_cnt, 40);

    // ACK_I toggling: 16-cycle bursts
    mode = 1;
    start_frame(3, 16);
    wait_done("toggle", 105);

    // preamble only
    mode = 0;
    start_frame(0, DPS + 1);
    wait_done("nsym0", 31);
    chk("nsym0_pay_acks", pay_seq - pay_base, 0);

    // restart request while busy is ignored
    start_frame(3, DPS + 1);
    repeat (20) step();
    FRM_START_I = 1'b1; FRM_NSYM_I = 8'd9;
    step();
    FRM_START_I = 1'b0; FRM_NSYM_I = 8'd0;
    wait_done("restart", 70);
    chk("restart_bursts", f_bursts, 5);

    // reset in the middle of payload symbol 0
    start_frame(3, DPS + 1);
    wait_pay("rst_reach_pay5", 5);
    RST_I = 1'b1;
    step();
    RST_I = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    start_frame(3, DPS + 1);
    wait_done("after_rst", 70);

    // source and sink stalls
    mode = 2;
    start_frame(2, 0);
    wait_done("stall", 0);
    chk("stall_words", hs_cnt, 32);
    mode = 0;
    step();

`ifdef SEQ_ABORT_EN
    start_frame(3, DPS + 1);
    wait_pay("abort_reach_pay3", 3);
    FRM_ABORT_I = 1'b1;
    step();
    FRM_ABORT_I = 1'b0;
    wait_done("abort", 0);
    chk("abort_bursts", f_bursts, PRE + 1);
    chk("abort_pay_words", pay_seq - pay_base, DPS);
    chk("done_count", done_cnt, 7);
`else
    chk("done_count", done_cnt, 6);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
